// File: rtl/tdc_stream_sequencer.sv
// tdc_stream_sequencer: orders pixel-tagged TDC timestamps into the
// histogram builder's wr_en/data stream over coarse and fine passes.
module tdc_stream_sequencer #(
  parameter int NP         = 16,
  parameter int DATA_NUM   = 2,
  parameter int PIXEL_NUM  = 4,
  parameter int ACQ_NUM    = 8,
  parameter int PASS_NUM   = 2,
  parameter int GAP_CYCLES = 4,
  parameter int PIX_W      = 2,
  localparam int PW = (PASS_NUM > 1) ? $clog2(PASS_NUM) : 1
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic [NP-1:0] in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [NP-1:0] data_out,
  output logic [PW-1:0] pass_idx,
  output logic          pass_last,
  output logic          busy,
  output logic          frame_done,
  output logic          err_order
);

  localparam int IW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [IW-1:0]    inp_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic [AW-1:0]    acq_cnt;
  logic [GW-1:0]    gap_cnt;

  logic inp_last, pix_last, acq_last;
  logic pass_end, pass_fin;
  logic accept, good;

  assign inp_last = (inp_cnt == IW'(DATA_NUM - 1));
  assign pix_last = (pix_cnt == PIX_W'(PIXEL_NUM - 1));
  assign acq_last = (acq_cnt == AW'(ACQ_NUM - 1));
  assign pass_end = inp_last & pix_last & acq_last;
  assign pass_fin = (pass_idx == PW'(PASS_NUM - 1));

  // ready depends only on registered state, never on in_valid
  assign in_ready = (state == S_STREAM);
  assign accept   = in_valid & in_ready;
  assign good     = accept & (in_pixel == pix_cnt);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= S_IDLE;
      inp_cnt    <= '0;
      pix_cnt    <= '0;
      acq_cnt    <= '0;
      gap_cnt    <= '0;
      pass_idx   <= '0;
      wr_en      <= 1'b0;
      data_out   <= '0;
      pass_last  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_order  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      pass_last  <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        inp_cnt  <= '0;
        pix_cnt  <= '0;
        acq_cnt  <= '0;
        gap_cnt  <= '0;
        pass_idx <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_STREAM;
              inp_cnt   <= '0;
              pix_cnt   <= '0;
              acq_cnt   <= '0;
              gap_cnt   <= '0;
              pass_idx  <= '0;
              err_order <= 1'b0;
              busy      <= 1'b1;
            end
          end
          S_STREAM: begin
            if (accept && !good) begin
              err_order <= 1'b1;
            end else if (good) begin
              wr_en    <= 1'b1;
              data_out <= in_data;
              inp_cnt  <= inp_last ? '0 : inp_cnt + IW'(1);
              if (inp_last) begin
                pix_cnt <= pix_last ? '0 : pix_cnt + PIX_W'(1);
                if (pix_last)
                  acq_cnt <= acq_last ? '0 : acq_cnt + AW'(1);
              end
              if (pass_end) begin
                pass_last <= 1'b1;
                gap_cnt   <= '0;
                state     <= pass_fin ? S_DONE : S_GAP;
              end
            end
          end
          S_GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
              state    <= S_STREAM;
              pass_idx <= pass_idx + PW'(1);
              gap_cnt  <= '0;
              inp_cnt  <= '0;
              pix_cnt  <= '0;
              acq_cnt  <= '0;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          S_DONE: begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
